// File: rtl/bomb_controller.sv
// bomb_controller
// Owns the player's single bomb. It places the bomb on the tile grid at the
// player's position, burns the fuse, and then drives the explosion window.
// Only one bomb is alive at a time.
//
// Ports
//   clk               system clock
//   reset_n           asynchronous, active-low reset
//   place_btn         debounced bomb button (level); its rising edge places a bomb
//   game_over         freezes the block: no placement, every counter holds
//   b_x, b_y          player sprite top-left, in pixels
//   bomb_x, bomb_y    top-left of the placed bomb tile
//   bomb_active       bomb is on the board and its fuse is burning
//   explosion_active  explosion is on screen (level)
//   explosion_SCEN    one-cycle pulse in the first explosion cycle
//   e_x, e_y          top-left of the explosion centre tile; valid with the pulse
module bomb_controller #(
    parameter int MIN_X         = 143,
    parameter int MIN_Y         = 34,
    parameter int TILE          = 16,
    parameter int TICK_LIMIT    = 25000000,
    parameter int FUSE_TICKS    = 3,
    parameter int EXPLODE_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       place_btn,
    input  logic       game_over,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    output logic [9:0] bomb_x,
    output logic [9:0] bomb_y,
    output logic       bomb_active,
    output logic       explosion_active,
    output logic       explosion_SCEN,
    output logic [9:0] e_x,
    output logic [9:0] e_y
);

    localparam int              TW        = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
    localparam logic [TW-1:0]   TICK_MAX  = TW'(TICK_LIMIT - 1);
    localparam logic [7:0]      FUSE_LAST = 8'(FUSE_TICKS - 1);
    localparam logic [7:0]      EXPL_LAST = 8'(EXPLODE_TICKS - 1);
    localparam logic [10:0]     HALF_TILE = 11'(TILE / 2);
    localparam logic [10:0]     TILE_MASK = ~11'(TILE - 1);
    localparam logic [10:0]     ORIGIN_X  = 11'(MIN_X);
    localparam logic [10:0]     ORIGIN_Y  = 11'(MIN_Y);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        EXPLODE = 2'd2
    } state_t;

    // Snap a sprite coordinate to the tile nearest its centre. TILE is a power
    // of two, so the divide/multiply pair reduces to clearing the low bits.
    function automatic logic [9:0] grid_snap(input logic [9:0] pos, input logic [10:0] origin);
        logic [10:0] offset;
        offset    = {1'b0, pos} + HALF_TILE - origin;
        offset    = offset & TILE_MASK;
        grid_snap = 10'(origin + offset);
    endfunction

    state_t        state_r, state_nxt_s;
    logic [TW-1:0] tick_cnt_r, tick_nxt_s;
    logic [7:0]    fuse_cnt_r, fuse_nxt_s;
    logic          btn_q_r;
    logic          rearm_block_r, rearm_block_nxt_s;
    logic [9:0]    bomb_x_r, bomb_x_nxt_s;
    logic [9:0]    bomb_y_r, bomb_y_nxt_s;
    logic [9:0]    e_x_r, e_x_nxt_s;
    logic [9:0]    e_y_r, e_y_nxt_s;
    logic          bomb_active_r, bomb_active_nxt_s;
    logic          expl_active_r, expl_active_nxt_s;
    logic          scen_r, scen_nxt_s;
    logic          press_s;
    logic          tick_s;

    assign press_s = place_btn & ~btn_q_r;
    assign tick_s  = (tick_cnt_r == TICK_MAX);

    // Next-state and next-output logic. rearm_block_r marks the first IDLE
    // cycle after an explosion so that a press landing on the return to IDLE
    // is dropped rather than starting a new bomb.
    always_comb begin
        state_nxt_s       = state_r;
        tick_nxt_s        = tick_cnt_r;
        fuse_nxt_s        = fuse_cnt_r;
        bomb_x_nxt_s      = bomb_x_r;
        bomb_y_nxt_s      = bomb_y_r;
        e_x_nxt_s         = e_x_r;
        e_y_nxt_s         = e_y_r;
        bomb_active_nxt_s = bomb_active_r;
        expl_active_nxt_s = expl_active_r;
        scen_nxt_s        = 1'b0;
        rearm_block_nxt_s = 1'b0;

        if (game_over) begin
            rearm_block_nxt_s = rearm_block_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (press_s && !rearm_block_r) begin
                        state_nxt_s       = ARMED;
                        bomb_x_nxt_s      = grid_snap(b_x, ORIGIN_X);
                        bomb_y_nxt_s      = grid_snap(b_y, ORIGIN_Y);
                        tick_nxt_s        = {TW{1'b0}};
                        fuse_nxt_s        = 8'd0;
                        bomb_active_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ARMED: begin
                    tick_nxt_s = tick_s ? {TW{1'b0}} : (tick_cnt_r + TW'(1));
                    if (tick_s) begin
                        if (fuse_cnt_r == FUSE_LAST) begin
                            state_nxt_s       = EXPLODE;
                            fuse_nxt_s        = 8'd0;
                            bomb_active_nxt_s = 1'b0;
                            expl_active_nxt_s = 1'b1;
                            scen_nxt_s        = 1'b1;
                            e_x_nxt_s         = bomb_x_r;
                            e_y_nxt_s         = bomb_y_r;
                        end else begin
                            fuse_nxt_s = fuse_cnt_r + 8'd1;
                        end
                    end else begin
                        fuse_nxt_s = fuse_cnt_r;
                    end
                end
                EXPLODE: begin
                    tick_nxt_s = tick_s ? {TW{1'b0}} : (tick_cnt_r + TW'(1));
                    if (tick_s) begin
                        if (fuse_cnt_r == EXPL_LAST) begin
                            state_nxt_s       = IDLE;
                            fuse_nxt_s        = 8'd0;
                            expl_active_nxt_s = 1'b0;
                            rearm_block_nxt_s = 1'b1;
                        end else begin
                            fuse_nxt_s = fuse_cnt_r + 8'd1;
                        end
                    end else begin
                        fuse_nxt_s = fuse_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s       = IDLE;
                    tick_nxt_s        = {TW{1'b0}};
                    fuse_nxt_s        = 8'd0;
                    bomb_active_nxt_s = 1'b0;
                    expl_active_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and registered-output update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            tick_cnt_r    <= {TW{1'b0}};
            fuse_cnt_r    <= 8'd0;
            btn_q_r       <= 1'b0;
            rearm_block_r <= 1'b0;
            bomb_x_r      <= 10'd0;
            bomb_y_r      <= 10'd0;
            e_x_r         <= 10'd0;
            e_y_r         <= 10'd0;
            bomb_active_r <= 1'b0;
            expl_active_r <= 1'b0;
            scen_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            tick_cnt_r    <= tick_nxt_s;
            fuse_cnt_r    <= fuse_nxt_s;
            btn_q_r       <= place_btn;
            rearm_block_r <= rearm_block_nxt_s;
            bomb_x_r      <= bomb_x_nxt_s;
            bomb_y_r      <= bomb_y_nxt_s;
            e_x_r         <= e_x_nxt_s;
            e_y_r         <= e_y_nxt_s;
            bomb_active_r <= bomb_active_nxt_s;
            expl_active_r <= expl_active_nxt_s;
            scen_r        <= scen_nxt_s;
        end
    end

    assign bomb_x           = bomb_x_r;
    assign bomb_y           = bomb_y_r;
    assign e_x              = e_x_r;
    assign e_y              = e_y_r;
    assign bomb_active      = bomb_active_r;
    assign explosion_active = expl_active_r;
    assign explosion_SCEN   = scen_r;

endmodule

// File: tb/tb_bomb_controller.sv
// tb_bomb_controller
// Directed bench for bomb_controller with TICK_LIMIT=4, FUSE_TICKS=3 and
// EXPLODE_TICKS=2. Inputs change and outputs are sampled on the falling edge.
// With a press seen at rising edge E0, sample n<k> is the falling edge after
// edge E<k-1>. The bomb is active for n1..n12, the pulse appears at n13, the
// explosion spans n13..n20, and IDLE is reached at n21.
module tb_bomb_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       place_btn;
    logic       game_over;
    logic [9:0] b_x, b_y;
    logic [9:0] bomb_x, bomb_y, e_x, e_y;
    logic       bomb_active, explosion_active, explosion_SCEN;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bomb_controller #(
        .MIN_X(143), .MIN_Y(34), .TILE(16),
        .TICK_LIMIT(4), .FUSE_TICKS(3), .EXPLODE_TICKS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .place_btn(place_btn), .game_over(game_over),
        .b_x(b_x), .b_y(b_y), .bomb_x(bomb_x), .bomb_y(bomb_y),
        .bomb_active(bomb_active), .explosion_active(explosion_active),
        .explosion_SCEN(explosion_SCEN), .e_x(e_x), .e_y(e_y)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press for one cycle; returns at sample n1 with the button released.
    task automatic press_once();
        place_btn = 1'b1;
        step(1);
        place_btn = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; place_btn = 1'b0; game_over = 1'b0; b_x = 10'd143; b_y = 10'd34;
        step(2);
        total++;
        if ({bomb_x, bomb_y, e_x, e_y} !== 40'd0) begin
            bad++; $display("FAIL reset_coords got=%h want=0", {bomb_x, bomb_y, e_x, e_y});
        end
        total++;
        if ({bomb_active, explosion_active, explosion_SCEN} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {bomb_active, explosion_active, explosion_SCEN});
        end
        reset_n = 1'b1;
        step(2);
    endtask

    task automatic test_single_bomb();
        logic exp_ba, exp_sc, exp_ea;
        b_x = 10'd150; b_y = 10'd40;
        press_once();
        total++;
        if (bomb_x !== 10'd143 || bomb_y !== 10'd34) begin
            bad++; $display("FAIL single_pos got=%0d,%0d want=143,34", bomb_x, bomb_y);
        end
        for (int i = 1; i <= 21; i++) begin
            exp_ba = (i <= 12);
            exp_sc = (i == 13);
            exp_ea = (i >= 13) && (i <= 20);
            total++;
            if ({bomb_active, explosion_SCEN, explosion_active} !== {exp_ba, exp_sc, exp_ea}) begin
                bad++; $display("FAIL single_seq n%0d got=%b want=%b", i,
                    {bomb_active, explosion_SCEN, explosion_active}, {exp_ba, exp_sc, exp_ea});
            end
            if (i == 13) begin
                total++;
                if (e_x !== 10'd143 || e_y !== 10'd34) begin
                    bad++; $display("FAIL single_epos got=%0d,%0d want=143,34", e_x, e_y);
                end
            end
            step(1);
        end
        step(3);
    endtask

    task automatic test_hold();
        int   pulses, places;
        logic prev_ba;
        pulses = 0; places = 0; prev_ba = 1'b0;
        b_x = 10'd160; b_y = 10'd60;
        place_btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 1) begin
                total++;
                if (bomb_x !== 10'd159 || bomb_y !== 10'd66) begin
                    bad++; $display("FAIL hold_pos got=%0d,%0d want=159,66", bomb_x, bomb_y);
                end
            end
            if (bomb_active && !prev_ba) places++;
            prev_ba = bomb_active;
            if (explosion_SCEN) begin
                pulses++;
                total++;
                if (e_x !== 10'd159 || e_y !== 10'd66) begin
                    bad++; $display("FAIL hold_epos got=%0d,%0d want=159,66", e_x, e_y);
                end
            end
        end
        place_btn = 1'b0;
        step(3);
        total++;
        if (places !== 1) begin
            bad++; $display("FAIL hold_places got=%0d want=1", places);
        end
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL hold_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_drop_press();
        b_x = 10'd150; b_y = 10'd40;
        press_once();                       // n1
        b_x = 10'd200;
        step(4);                            // n5: press seen at E5
        place_btn = 1'b1;
        step(1);                            // n6
        place_btn = 1'b0;
        total++;
        if (bomb_active !== 1'b1 || bomb_x !== 10'd143) begin
            bad++; $display("FAIL drop_busy got=%b,%0d want=1,143", bomb_active, bomb_x);
        end
        step(7);                            // n13
        total++;
        if (explosion_SCEN !== 1'b1) begin
            bad++; $display("FAIL drop_timing got=%b want=1", explosion_SCEN);
        end
        step(8);                            // n21: first IDLE cycle
        total++;
        if (explosion_active !== 1'b0 || bomb_active !== 1'b0) begin
            bad++; $display("FAIL drop_idle got=%b,%b want=0,0", explosion_active, bomb_active);
        end
        place_btn = 1'b1;
        step(1);                            // n22
        place_btn = 1'b0;
        total++;
        if (bomb_active !== 1'b0) begin
            bad++; $display("FAIL drop_first_idle got=%b want=0", bomb_active);
        end
        step(1);                            // n23
        place_btn = 1'b1;
        step(1);                            // n24
        place_btn = 1'b0;
        total++;
        if (bomb_active !== 1'b1 || bomb_x !== 10'd207 || bomb_y !== 10'd34) begin
            bad++; $display("FAIL drop_accept got=%b,%0d,%0d want=1,207,34", bomb_active, bomb_x, bomb_y);
        end
        step(24);
    endtask

    task automatic test_freeze();
        b_x = 10'd150; b_y = 10'd40;
        press_once();                       // n1
        step(2);                            // n3
        game_over = 1'b1;                   // freezes E3..E12
        step(1);
        place_btn = 1'b1;
        step(1);
        place_btn = 1'b0;
        step(8);                            // n13
        game_over = 1'b0;
        for (int i = 13; i <= 22; i++) begin
            total++;
            if (explosion_SCEN !== 1'b0 || bomb_active !== 1'b1) begin
                bad++; $display("FAIL freeze_hold n%0d got=%b,%b want=0,1", i, explosion_SCEN, bomb_active);
            end
            step(1);
        end
        total++;                            // n23
        if (explosion_SCEN !== 1'b1 || bomb_x !== 10'd143) begin
            bad++; $display("FAIL freeze_fire got=%b,%0d want=1,143", explosion_SCEN, bomb_x);
        end
        step(12);
        game_over = 1'b1;
        b_x = 10'd200;
        press_once();
        step(2);
        game_over = 1'b0;
        step(2);
        total++;
        if (bomb_active !== 1'b0) begin
            bad++; $display("FAIL freeze_press got=%b want=0", bomb_active);
        end
        step(2);
    endtask

    task automatic test_freeze_on_tick();
        b_x = 10'd150; b_y = 10'd40;
        press_once();                       // n1
        step(11);                           // n12
        game_over = 1'b1;                   // detonation edge E12 frozen
        for (int i = 13; i <= 15; i++) begin
            step(1);
            total++;
            if (explosion_SCEN !== 1'b0 || bomb_active !== 1'b1 || explosion_active !== 1'b0) begin
                bad++; $display("FAIL tick_freeze n%0d got=%b%b%b want=010", i,
                    explosion_SCEN, bomb_active, explosion_active);
            end
        end
        game_over = 1'b0;
        step(1);                            // n16
        total++;
        if (explosion_SCEN !== 1'b1 || e_x !== 10'd143) begin
            bad++; $display("FAIL tick_release got=%b,%0d want=1,143", explosion_SCEN, e_x);
        end
        step(12);
    endtask

    task automatic test_reset_mid();
        int seen;
        b_x = 10'd150; b_y = 10'd40;
        press_once();
        step(4);
        reset_n = 1'b0;
        #1;
        total++;
        if ({bomb_active, bomb_x, bomb_y} !== 21'd0) begin
            bad++; $display("FAIL rst_armed got=%b,%0d,%0d want=0,0,0", bomb_active, bomb_x, bomb_y);
        end
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen += int'(explosion_SCEN | bomb_active | explosion_active);
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rst_armed_quiet got=%0d want=0", seen);
        end
        press_once();
        step(14);                           // n15, inside EXPLODE
        total++;
        if (explosion_active !== 1'b1) begin
            bad++; $display("FAIL rst_pre_explode got=%b want=1", explosion_active);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({explosion_active, explosion_SCEN, e_x, e_y} !== 22'd0) begin
            bad++; $display("FAIL rst_explode got=%b,%b,%0d,%0d want=0,0,0,0",
                explosion_active, explosion_SCEN, e_x, e_y);
        end
        #1 reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen += int'(explosion_SCEN | bomb_active | explosion_active);
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL rst_explode_quiet got=%0d want=0", seen);
        end
        b_x = 10'd160; b_y = 10'd60;
        press_once();
        total++;
        if (bomb_active !== 1'b1 || bomb_x !== 10'd159 || bomb_y !== 10'd66) begin
            bad++; $display("FAIL rst_new_place got=%b,%0d,%0d want=1,159,66", bomb_active, bomb_x, bomb_y);
        end
        step(12);                           // n13
        total++;
        if (explosion_SCEN !== 1'b1 || e_x !== 10'd159) begin
            bad++; $display("FAIL rst_new_fire got=%b,%0d want=1,159", explosion_SCEN, e_x);
        end
        step(10);
    endtask

    initial begin
        test_reset();
        test_single_bomb();
        test_hold();
        test_drop_press();
        test_freeze();
        test_freeze_on_tick();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
